// File: rtl/router_input_arbiter_pkg.sv
// Shared sizing helpers and default dimensions for the router input arbiter.
package router_input_arbiter_pkg;

  // Number of bits needed to hold the value v (minimum 1).
  function automatic int clogb2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  localparam int NPORTS_DEF      = 5;
  localparam int NVCS_DEF        = 2;
  localparam int STALL_LIMIT_DEF = 15;

endpackage

// File: rtl/router_input_arbiter_if.sv
// Handshake bundle between the input VC FIFOs / stage 2 and the input arbiter.
interface router_input_arbiter_if #(
  parameter int NINPUTS     = 10,
  parameter int LOG_NINPUTS = 4
);
  logic                   enable;
  logic [NINPUTS-1:0]     req;
  logic [NINPUTS-1:0]     block;
  logic                   s2_routed;
  logic                   grant_valid;
  logic [LOG_NINPUTS-1:0] grant_id;
  logic [NINPUTS-1:0]     grant_onehot;
  logic [NINPUTS-1:0]     flit_ack;
  logic                   error;
  logic                   is_quiescent;

  modport master (
    output enable, req, block, s2_routed,
    input  grant_valid, grant_id, grant_onehot, flit_ack, error, is_quiescent
  );

  modport slave (
    input  enable, req, block, s2_routed,
    output grant_valid, grant_id, grant_onehot, flit_ack, error, is_quiescent
  );
endinterface

// File: rtl/router_input_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of elig_i at or above ptr_i, wrapping.
module rr_priority_pick #(
  parameter int N = 10,
  parameter int W = 4
) (
  input  logic [N-1:0] elig_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] pick_o,
  output logic         found_o
);
  logic [2*N-1:0] masked;

  always_comb begin
    // Lower copy is masked below ptr, upper copy stays whole and supplies the wrap.
    masked  = {elig_i, elig_i} & ({(2*N){1'b1}} << ptr_i);
    pick_o  = '0;
    found_o = 1'b0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (masked[i]) begin
        found_o = 1'b1;
        pick_o  = W'(i % N);
      end
    end
  end
endmodule

// File: rtl/router_input_arbiter.sv
// Round-robin input VC scheduler feeding the single stage-2 slot, with retry priority
// for failed flits and a sticky starvation flag.
module router_input_arbiter
  import router_input_arbiter_pkg::*;
#(
  parameter int NPORTS      = NPORTS_DEF,
  parameter int NVCS        = NVCS_DEF,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  router_input_arbiter_if.slave arb
);
  localparam int NINPUTS     = NPORTS * NVCS;
  localparam int LOG_NINPUTS = clogb2(NINPUTS - 1);
  localparam int CNT_W       = clogb2(STALL_LIMIT);

  logic                   gv_q, gv_d;
  logic [LOG_NINPUTS-1:0] gid_q, gid_d;
  logic [LOG_NINPUTS-1:0] ptr_q, ptr_d;
  logic [LOG_NINPUTS-1:0] lf_q, lf_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [LOG_NINPUTS-1:0] pick;
  logic                   found;
  logic [NINPUTS-1:0]     onehot;
  logic [NINPUTS-1:0]     elig;

  // The slot's input is excluded even when routed: its req still reflects the flit being popped.
  always_comb begin
    onehot = gv_q ? (NINPUTS'(1) << gid_q) : '0;
    elig   = arb.req & ~arb.block & ~onehot;
  end

  rr_priority_pick #(
    .N (NINPUTS),
    .W (LOG_NINPUTS)
  ) u_pick (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .pick_o  (pick),
    .found_o (found)
  );

  always_comb begin
    gv_d  = gv_q;
    gid_d = gid_q;
    ptr_d = ptr_q;
    lf_d  = lf_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (arb.enable) begin
      gv_d = found;
      if (found) begin
        gid_d = pick;
        ptr_d = (pick == LOG_NINPUTS'(NINPUTS - 1)) ? '0 : pick + 1'b1;
      end
      if (gv_q) begin
        if (arb.s2_routed) begin
          cnt_d = '0;
        end else begin
          // A failed flit takes priority over the pick-based pointer advance.
          ptr_d = gid_q;
          lf_d  = gid_q;
          if (gid_q != lf_q)                     cnt_d = CNT_W'(1);
          else if (cnt_q != CNT_W'(STALL_LIMIT)) cnt_d = cnt_q + 1'b1;
        end
      end
      if (cnt_d == CNT_W'(STALL_LIMIT)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gv_q  <= 1'b0;
      gid_q <= '0;
      ptr_q <= '0;
      lf_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      gv_q  <= gv_d;
      gid_q <= gid_d;
      ptr_q <= ptr_d;
      lf_q  <= lf_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign arb.grant_valid  = gv_q;
  assign arb.grant_id     = gid_q;
  assign arb.grant_onehot = onehot;
  assign arb.flit_ack     = onehot & {NINPUTS{arb.s2_routed & arb.enable}};
  assign arb.error        = err_q;
  assign arb.is_quiescent = ~gv_q & ~(|arb.req);
endmodule

// File: tb/tb_router_input_arbiter.sv
// Randomized and directed bench for router_input_arbiter against a behavioural scheduler model.
module tb_router_input_arbiter;
  import router_input_arbiter_pkg::*;

  localparam int N   = 10;
  localparam int LOG = 4;
  localparam int LIM = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  router_input_arbiter_if #(.NINPUTS(N), .LOG_NINPUTS(LOG)) arb_if();

  router_input_arbiter #(
    .NPORTS      (5),
    .NVCS        (2),
    .STALL_LIMIT (LIM)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .arb    (arb_if)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference scheduler state: slot contents, search start, consecutive-failure tracking.
  int m_gv, m_gid, m_ptr, m_cnt, m_lf, m_err;
  logic [N-1:0] last_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gv = 0; m_gid = 0; m_ptr = 0; m_cnt = 0; m_lf = 0; m_err = 0;
  endtask

  // Drive one cycle of inputs, compare the visible outputs, then advance the model past the edge.
  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] b, input logic s, input logic e);
    logic [N-1:0] oh;
    int pick;
    bit found;
    @(negedge clk);
    arb_if.req = r; arb_if.block = b; arb_if.s2_routed = s; arb_if.enable = e;
    #1;
    oh = '0;
    if (m_gv != 0) oh[m_gid] = 1'b1;
    chk("grant_valid", 32'(arb_if.grant_valid), 32'(m_gv));
    if (m_gv != 0) chk("grant_id", 32'(arb_if.grant_id), 32'(m_gid));
    chk("grant_onehot", 32'(arb_if.grant_onehot), 32'(oh));
    chk("flit_ack", 32'(arb_if.flit_ack), (e && s) ? 32'(oh) : 32'd0);
    chk("error", 32'(arb_if.error), 32'(m_err));
    chk("is_quiescent", 32'(arb_if.is_quiescent), (m_gv == 0 && r == '0) ? 32'd1 : 32'd0);
    last_ack = arb_if.flit_ack;
    if (e) begin
      found = 0; pick = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && r[idx] && !b[idx] && !(m_gv != 0 && idx == m_gid)) begin
          found = 1; pick = idx;
        end
      end
      if (m_gv != 0) begin
        if (s) m_cnt = 0;
        else begin
          if (m_gid == m_lf) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
          else               m_cnt = 1;
          m_lf = m_gid;
        end
      end
      if (m_cnt == LIM) m_err = 1;
      if (m_gv != 0 && !s) m_ptr = m_gid;
      else if (found)      m_ptr = (pick + 1) % N;
      m_gv = found ? 1 : 0;
      if (found) m_gid = pick;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] r, b, all1, bit2_7, bit3, bit4, bit5;
    int acks, hit;
    all1   = '1;
    bit2_7 = '0; bit2_7[2] = 1'b1; bit2_7[7] = 1'b1;
    bit3   = '0; bit3[3] = 1'b1;
    bit4   = '0; bit4[4] = 1'b1;
    bit5   = '0; bit5[5] = 1'b1;

    rst_n = 1'b0;
    arb_if.req = '0; arb_if.block = '0; arb_if.s2_routed = 1'b0; arb_if.enable = 1'b0;
    model_reset();
    #12;
    chk("rst_grant_valid", 32'(arb_if.grant_valid), 32'd0);
    chk("rst_onehot", 32'(arb_if.grant_onehot), 32'd0);
    chk("rst_flit_ack", 32'(arb_if.flit_ack), 32'd0);
    chk("rst_error", 32'(arb_if.error), 32'd0);
    chk("rst_quiescent", 32'(arb_if.is_quiescent), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // All inputs requesting, everything routed: strict rotation 0..9,0.
    for (int i = 0; i < 11; i++) begin
      cycle(all1, '0, 1'b1, 1'b1);
      @(posedge clk); #1;
      chk("rr_seq", 32'(arb_if.grant_id), 32'(i % N));
    end

    // Single requester: granted every other cycle.
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(bit3, '0, 1'b1, 1'b1);
      acks += int'(last_ack[3]);
    end
    chk("single_acks", 32'(acks), 32'd10);

    // Retry priority: input 2 fails once, then wins the next free pick.
    cycle(bit2_7, '0, 1'b1, 1'b1);
    cycle(bit2_7, '0, 1'b1, 1'b1);
    cycle(bit2_7, '0, 1'b0, 1'b1);
    cycle(bit2_7, '0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("retry_first", 32'(arb_if.grant_id), 32'd2);
    cycle(bit2_7, '0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("retry_then", 32'(arb_if.grant_id), 32'd7);

    // Blocked requester is never picked and keeps the arbiter non-quiescent.
    for (int i = 0; i < 3; i++) cycle(bit5, bit5, 1'b1, 1'b1);
    chk("block_gv", 32'(arb_if.grant_valid), 32'd0);
    chk("block_quiescent", 32'(arb_if.is_quiescent), 32'd0);
    cycle(bit5, '0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("unblock_gv", 32'(arb_if.grant_valid), 32'd1);
    chk("unblock_id", 32'(arb_if.grant_id), 32'd5);

    // Starvation: input 4 fails repeatedly until the sticky error rises.
    for (int i = 0; i < 32; i++) cycle(bit4, '0, 1'b0, 1'b1);
    chk("err_set", 32'(arb_if.error), 32'd1);
    for (int i = 0; i < 4; i++) cycle(bit4, '0, 1'b1, 1'b1);
    chk("err_sticky", 32'(arb_if.error), 32'd1);

    // Asynchronous reset while a grant is live and the pointer sits at 6.
    hit = 0;
    for (int i = 0; i < 30 && hit == 0; i++) begin
      cycle(all1, '0, 1'b1, 1'b1);
      if (m_ptr == 6 && m_gv != 0) hit = 1;
    end
    chk("reach_ptr6", 32'(hit), 32'd1);
    @(posedge clk); #2;
    chk("pre_rst_gv", 32'(arb_if.grant_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gv", 32'(arb_if.grant_valid), 32'd0);
    chk("mid_rst_id", 32'(arb_if.grant_id), 32'd0);
    chk("mid_rst_ack", 32'(arb_if.flit_ack), 32'd0);
    chk("mid_rst_err", 32'(arb_if.error), 32'd0);
    model_reset();
    arb_if.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(all1, '0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("post_rst_first", 32'(arb_if.grant_id), 32'd0);

    // Randomized traffic with stalls, blocks, failures and idle periods.
    for (int i = 0; i < 400; i++) begin
      r = N'($urandom);
      if ($urandom_range(0, 5) == 0) r = '0;
      b = N'($urandom & $urandom & $urandom);
      cycle(r, b, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
